// File: rtl/sottrattore_seriale_if.sv
// Handshake/operand bundle for sottrattore_seriale.
// The overflow signal exists only when SOTT_OVERFLOW_EN is defined.
interface sottrattore_seriale_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] x1;
  logic [N-1:0] x2;
  logic         busy;
  logic         done;
  logic [N-1:0] differenza;
  logic         prestito;
`ifdef SOTT_OVERFLOW_EN
  logic         overflow;

  modport master (output start, x1, x2,
                  input  busy, done, differenza, prestito, overflow);
  modport slave  (input  start, x1, x2,
                  output busy, done, differenza, prestito, overflow);
`else
  modport master (output start, x1, x2,
                  input  busy, done, differenza, prestito);
  modport slave  (input  start, x1, x2,
                  output busy, done, differenza, prestito);
`endif
endinterface

// File: rtl/sottrattore_seriale.sv
// Bit-serial N-bit subtractor (x1 - x2), LSB first, one bit per clock.
// Optional two's-complement overflow flag enabled by SOTT_OVERFLOW_EN.
module sottrattore_seriale #(
  parameter int unsigned N = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  sottrattore_seriale_if.slave    bus
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, FINE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          r_q, r_d;
  logic          pre_q, pre_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_d, borrow;
`ifdef SOTT_OVERFLOW_EN
  logic          x1m_q, x1m_d, x2m_q, x2m_d;
  logic          ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs and the held borrow
  always_comb begin
    bit_d  = a_q[0] ^ b_q[0] ^ r_q;
    borrow = (~a_q[0] & b_q[0]) | (~a_q[0] & r_q) | (b_q[0] & r_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
`ifdef SOTT_OVERFLOW_EN
    x1m_d   = x1m_q;
    x2m_d   = x2m_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.x1;
          b_d     = bus.x2;
          res_d   = '0;
          r_d     = 1'b0;
          cnt_d   = '0;
          diff_d  = '0;
          pre_d   = 1'b0;
`ifdef SOTT_OVERFLOW_EN
          x1m_d   = bus.x1[N-1];
          x2m_d   = bus.x2[N-1];
          ovf_d   = 1'b0;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        r_d   = borrow;
        a_d   = {1'b0, a_q[N-1:1]};
        b_d   = {1'b0, b_q[N-1:1]};
        res_d = {bit_d, res_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = FINE;
      end
      FINE: begin
        // Result is published one edge after FINE so every output stays registered
        done_d  = 1'b1;
        diff_d  = res_q;
        pre_d   = r_q;
`ifdef SOTT_OVERFLOW_EN
        ovf_d   = (x1m_q != x2m_q) && (res_q[N-1] != x1m_q);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      r_q     <= 1'b0;
      pre_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SOTT_OVERFLOW_EN
      x1m_q   <= 1'b0;
      x2m_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SOTT_OVERFLOW_EN
      x1m_q   <= x1m_d;
      x2m_q   <= x2m_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.differenza = diff_q;
  assign bus.prestito   = pre_q;
`ifdef SOTT_OVERFLOW_EN
  assign bus.overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_sottrattore_seriale.sv
// Directed and randomised checks for sottrattore_seriale with N=8.
// Overflow checks are compiled in only when SOTT_OVERFLOW_EN is defined.
module tb_sottrattore_seriale;

  localparam int unsigned N = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sottrattore_seriale_if #(.N(N)) bus ();

  sottrattore_seriale #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete operation with start pulsed for a single cycle
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_p, input logic exp_o);
    int lat;
    bit seen;
    bus.x1 = a;
    bus.x2 = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.x1 = ~a;
    bus.x2 = ~b;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_clr"}, {23'd0, bus.prestito, bus.differenza}, 32'd0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      tick();
      lat++;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_timeout"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, lat, N + 1);
    chk({tag, "_diff"}, 32'(bus.differenza), 32'(exp_d));
    chk({tag, "_prest"}, 32'(bus.prestito), 32'(exp_p));
`ifdef SOTT_OVERFLOW_EN
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_o));
`else
    if (exp_o === 1'bx) chk({tag, "_ovf_x"}, 32'(exp_o), 32'd0);
`endif
    tick();
    chk({tag, "_done_w"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"}, {23'd0, bus.prestito, bus.differenza}, {23'd0, exp_p, exp_d});
  endtask

  initial begin
    logic [7:0] ra, rb, rd;
    logic [7:0] ox1 [4];
    logic [7:0] ox2 [4];
    logic [7:0] od  [3];
    logic       op  [3];
    logic       oo  [3];
    bit         stray;

    bus.start = 1'b0;
    bus.x1 = '0;
    bus.x2 = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", {23'd0, bus.prestito, bus.differenza}, 32'd0);
`ifdef SOTT_OVERFLOW_EN
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
`endif
    reset = 1'b0;
    tick();

    do_op("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    do_op("t2", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    do_op("t3", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op("b_zero_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    do_op("b_equal", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_op("b_7f_80", 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1);

    // Start held high; operands switched right after each accepting edge
    ox1 = '{8'h10, 8'hAA, 8'h33, 8'h77};
    ox2 = '{8'h04, 8'h55, 8'h44, 8'h77};
    od  = '{8'h0C, 8'h55, 8'hEF};
    op  = '{1'b0, 1'b0, 1'b1};
    oo  = '{1'b0, 1'b1, 1'b0};
    bus.x1 = ox1[0];
    bus.x2 = ox2[0];
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.x1 = ox1[i+1];
      bus.x2 = ox2[i+1];
      for (int e = 1; e <= 8; e++) begin
        tick();
        chk($sformatf("t4_nodone%0d_%0d", i, e), 32'(bus.done), 32'd0);
      end
      tick();
      chk($sformatf("t4_done%0d", i), 32'(bus.done), 32'd1);
      chk($sformatf("t4_diff%0d", i), 32'(bus.differenza), 32'(od[i]));
      chk($sformatf("t4_prest%0d", i), 32'(bus.prestito), 32'(op[i]));
`ifdef SOTT_OVERFLOW_EN
      chk($sformatf("t4_ovf%0d", i), 32'(bus.overflow), 32'(oo[i]));
`endif
      if (i == 2) bus.start = 1'b0;
      tick();
      chk($sformatf("t4_drop%0d", i), 32'(bus.done), 32'd0);
      chk($sformatf("t4_busy%0d", i), 32'(bus.busy), (i == 2) ? 32'd0 : 32'd1);
    end
    tick();

    // Reset during the fourth CALC cycle aborts without a done
    bus.x1 = 8'h9C;
    bus.x2 = 8'h21;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_out", {23'd0, bus.prestito, bus.differenza}, 32'd0);
    reset = 1'b0;
    stray = 1'b0;
    repeat (15) begin
      tick();
      if (bus.done || bus.busy) stray = 1'b1;
    end
    chk("t5_no_done", 32'(stray), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rd = ra - rb;
      do_op("rand", ra, rb, rd, ra < rb, (ra[7] != rb[7]) && (rd[7] != ra[7]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "global timeout");
  end

endmodule
